// File: rtl/gpu_prim_queue_if.sv
// Primitive queue bus bundle.
// Carries the writeback-side push signals (lock, GSR value, vertex triple,
// push valid, stall), the rasterizer-side beat stream (valid/ready, GSR,
// vertex, vertex index, last) and the status outputs (occupancy, overflow).
//   slave  : the queue itself (consumes pushes and ready, produces beats/status)
//   master : the environment around it (writeback + rasterizer)
interface gpu_prim_queue_if #(
    parameter int DEPTH = 4,
    parameter int GSR_W = 8,
    parameter int VTX_W = 30
);
    localparam int CNT_W = $clog2(DEPTH) + 1;

    logic               I_LOCK;
    logic [GSR_W-1:0]   I_GSRValue;
    logic               I_GSRValue_Valid;
    logic [VTX_W-1:0]   I_VertexV1;
    logic [VTX_W-1:0]   I_VertexV2;
    logic [VTX_W-1:0]   I_VertexV3;
    logic               I_RAST_Ready;
    logic               O_GPUStallSignal;
    logic               O_PrimValid;
    logic [GSR_W-1:0]   O_PrimGSR;
    logic [VTX_W-1:0]   O_PrimVertex;
    logic [1:0]         O_PrimVertexIdx;
    logic               O_PrimLast;
    logic [CNT_W-1:0]   O_Count;
    logic               O_Overflow;

    modport slave (
        input  I_LOCK, I_GSRValue, I_GSRValue_Valid,
        input  I_VertexV1, I_VertexV2, I_VertexV3, I_RAST_Ready,
        output O_GPUStallSignal, O_PrimValid, O_PrimGSR, O_PrimVertex,
        output O_PrimVertexIdx, O_PrimLast, O_Count, O_Overflow
    );

    modport master (
        output I_LOCK, I_GSRValue, I_GSRValue_Valid,
        output I_VertexV1, I_VertexV2, I_VertexV3, I_RAST_Ready,
        input  O_GPUStallSignal, O_PrimValid, O_PrimGSR, O_PrimVertex,
        input  O_PrimVertexIdx, O_PrimLast, O_Count, O_Overflow
    );
endinterface

// File: rtl/gpu_prim_queue.sv
// Primitive queue between writeback and the rasterizer.
// Captures one primitive (GSR value + three vertices) per push, buffers up to
// DEPTH primitives, and streams each one as three valid/ready beats
// (V1, V2, V3; the V3 beat carries O_PrimLast). Raises O_GPUStallSignal early
// enough that writeback never overruns the queue.
// Ports:
//   I_CLOCK   : clock; all state changes on the falling edge
//   I_RESET_N : asynchronous active-low reset
//   q         : gpu_prim_queue_if.slave bundle (push side, beat side, status)
// DEPTH must be a power of two and at least 2 (pointers wrap by overflow).
module gpu_prim_queue #(
    parameter int DEPTH = 4,
    parameter int GSR_W = 8,
    parameter int VTX_W = 30
) (
    input  logic              I_CLOCK,
    input  logic              I_RESET_N,
    gpu_prim_queue_if.slave   q
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int ENT_W = GSR_W + 3 * VTX_W;

    // The state code doubles as the vertex index presented on the bus.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_V1   = 2'd1;
    localparam logic [1:0] ST_V2   = 2'd2;
    localparam logic [1:0] ST_V3   = 2'd3;

    logic [1:0]       state_reg, state_next;
    logic [PTR_W-1:0] wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0] count_reg, count_next;
    logic             stall_reg;
    logic             overflow_reg;

    // Entry storage is deliberately not reset; only the pointers are.
    logic [ENT_W-1:0] entry_mem [DEPTH];

    logic             push_req;
    logic             push_accept;
    logic             pop;
    logic [ENT_W-1:0] head;
    logic [GSR_W-1:0] head_gsr;
    logic [VTX_W-1:0] head_v1, head_v2, head_v3;

    assign push_req = q.I_GSRValue_Valid & q.I_LOCK;
    assign pop      = (state_reg == ST_V3) & q.I_RAST_Ready;
    // A full queue still takes a push when the head leaves on the same edge.
    assign push_accept = push_req & ((count_reg != CNT_W'(DEPTH)) | pop);
    assign count_next  = count_reg + CNT_W'(push_accept) - CNT_W'(pop);

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            // Uses the pre-edge count, so a push into an empty queue shows
            // up as a valid beat one edge after the push.
            ST_IDLE: if (count_reg != '0) state_next = ST_V1;
            ST_V1:   if (q.I_RAST_Ready) state_next = ST_V2;
            ST_V2:   if (q.I_RAST_Ready) state_next = ST_V3;
            ST_V3: begin
                if (q.I_RAST_Ready) begin
                    // Another primitive already waiting: no idle bubble.
                    state_next = (count_reg > CNT_W'(1)) ? ST_V1 : ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(negedge I_CLOCK or negedge I_RESET_N) begin
        if (!I_RESET_N) begin
            state_reg    <= ST_IDLE;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            stall_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            state_reg <= state_next;
            count_reg <= count_next;
            // One entry of headroom covers writeback's one-cycle reaction.
            stall_reg <= (count_next >= CNT_W'(DEPTH - 1));
            if (push_accept) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (pop)         rd_ptr_reg <= rd_ptr_reg + 1'b1;
            if (push_req && !push_accept) overflow_reg <= 1'b1;
        end
    end

    always_ff @(negedge I_CLOCK) begin
        if (push_accept) begin
            entry_mem[wr_ptr_reg] <= {q.I_GSRValue, q.I_VertexV1,
                                      q.I_VertexV2, q.I_VertexV3};
        end
    end

    assign head     = entry_mem[rd_ptr_reg];
    assign head_gsr = head[ENT_W-1 -: GSR_W];
    assign head_v1  = head[3*VTX_W-1 -: VTX_W];
    assign head_v2  = head[2*VTX_W-1 -: VTX_W];
    assign head_v3  = head[VTX_W-1 -: VTX_W];

    // Beat outputs decode directly from the state register, so they hold
    // while ready is low and drop to zero as soon as reset asserts.
    always_comb begin
        q.O_PrimVertex = '0;
        case (state_reg)
            ST_V1:   q.O_PrimVertex = head_v1;
            ST_V2:   q.O_PrimVertex = head_v2;
            ST_V3:   q.O_PrimVertex = head_v3;
            default: q.O_PrimVertex = '0;
        endcase
    end

    assign q.O_PrimValid      = (state_reg != ST_IDLE);
    assign q.O_PrimVertexIdx  = state_reg;
    assign q.O_PrimLast       = (state_reg == ST_V3);
    assign q.O_PrimGSR        = (state_reg != ST_IDLE) ? head_gsr : '0;
    assign q.O_Count          = count_reg;
    assign q.O_GPUStallSignal = stall_reg;
    assign q.O_Overflow       = overflow_reg;
endmodule

// File: tb/tb_gpu_prim_queue.sv
// Randomised and directed bench for gpu_prim_queue against a queue-based
// behavioural model plus an accepted-beat scoreboard.
module tb_gpu_prim_queue;
    localparam int DEPTH = 4;
    localparam int GSR_W = 8;
    localparam int VTX_W = 30;
    localparam int CNT_W = 3;

    logic clk = 1'b1;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpu_prim_queue_if #(.DEPTH(DEPTH), .GSR_W(GSR_W), .VTX_W(VTX_W)) bus ();

    gpu_prim_queue #(.DEPTH(DEPTH), .GSR_W(GSR_W), .VTX_W(VTX_W)) dut (
        .I_CLOCK   (clk),
        .I_RESET_N (rst_n),
        .q         (bus)
    );

    typedef struct packed {
        logic [GSR_W-1:0] g;
        logic [VTX_W-1:0] a;
        logic [VTX_W-1:0] b;
        logic [VTX_W-1:0] c;
    } prim_t;
    typedef logic [GSR_W+VTX_W+1:0] beat_t;

    int checks = 0;
    int passed = 0;

    // Model: queue of stored primitives, which vertex (0 = none) is on the bus.
    prim_t mq[$];
    int    m_beat = 0;
    bit    m_ovf = 0;
    beat_t exp_beats[$];
    beat_t got_beats[$];
    prim_t zp = '0;

    function automatic prim_t rand_prim();
        prim_t p;
        p.g = GSR_W'($urandom);
        p.a = VTX_W'($urandom);
        p.b = VTX_W'($urandom);
        p.c = VTX_W'($urandom);
        return p;
    endfunction

    task automatic model_step(input bit push, input bit lock, input bit ready, input prim_t p);
        int sz = mq.size();
        bit pop = (m_beat == 3) && ready;
        bit req = push && lock;
        bit acc = req && ((sz < DEPTH) || pop);
        if (m_beat == 0) m_beat = (sz != 0) ? 1 : 0;
        else if (ready) m_beat = (m_beat == 3) ? ((sz > 1) ? 1 : 0) : m_beat + 1;
        if (pop) void'(mq.pop_front());
        if (acc) begin
            mq.push_back(p);
            exp_beats.push_back({p.g, p.a, 2'd1});
            exp_beats.push_back({p.g, p.b, 2'd2});
            exp_beats.push_back({p.g, p.c, 2'd3});
        end
        if (req && !acc) m_ovf = 1;
    endtask

    function automatic logic [46:0] obs_vec();
        logic v = bus.O_PrimValid;
        return {v, bus.O_PrimVertexIdx, bus.O_PrimLast,
                v ? bus.O_PrimGSR : 8'h0, v ? bus.O_PrimVertex : 30'h0,
                bus.O_Count, bus.O_GPUStallSignal, bus.O_Overflow};
    endfunction

    function automatic logic [46:0] exp_vec();
        logic [GSR_W-1:0] g = '0;
        logic [VTX_W-1:0] vx = '0;
        if (m_beat != 0) begin
            g  = mq[0].g;
            vx = (m_beat == 1) ? mq[0].a : (m_beat == 2) ? mq[0].b : mq[0].c;
        end
        return {m_beat != 0, 2'(m_beat), m_beat == 3, g, vx,
                CNT_W'(mq.size()), mq.size() >= DEPTH - 1, m_ovf};
    endfunction

    // Drive one falling-edge worth of inputs; returns at posedge+1.
    task automatic cycle(input bit push, input bit lock, input bit ready, input prim_t p);
        bus.I_GSRValue_Valid = push;
        bus.I_LOCK           = lock;
        bus.I_RAST_Ready     = ready;
        bus.I_GSRValue       = p.g;
        bus.I_VertexV1       = p.a;
        bus.I_VertexV2       = p.b;
        bus.I_VertexV3       = p.c;
        if (bus.O_PrimValid && ready)
            got_beats.push_back({bus.O_PrimGSR, bus.O_PrimVertex, bus.O_PrimVertexIdx});
        @(negedge clk);
        model_step(push, lock, ready, p);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.I_GSRValue_Valid = 0; bus.I_LOCK = 0; bus.I_RAST_Ready = 0;
        bus.I_GSRValue = '0; bus.I_VertexV1 = '0; bus.I_VertexV2 = '0; bus.I_VertexV3 = '0;
        repeat (2) @(posedge clk);
        #1;
        mq.delete(); m_beat = 0; m_ovf = 0;
        exp_beats.delete(); got_beats.delete();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if ({bus.O_PrimValid, bus.O_PrimVertexIdx, bus.O_PrimLast, bus.O_PrimGSR, bus.O_PrimVertex,
             bus.O_Count, bus.O_GPUStallSignal, bus.O_Overflow} !== 47'h0)
            $display("FAIL reset_outputs got valid=%b idx=%0d gsr=%h vtx=%h cnt=%0d stall=%b ovf=%b want all 0",
                     bus.O_PrimValid, bus.O_PrimVertexIdx, bus.O_PrimGSR, bus.O_PrimVertex,
                     bus.O_Count, bus.O_GPUStallSignal, bus.O_Overflow);
        else passed++;
    endtask

    task automatic test_single();
        prim_t p = {8'h05, 30'h1, 30'h2, 30'h3};
        do_reset();
        for (int i = 0; i < 6; i++) begin
            cycle(i == 0, 1, 1, (i == 0) ? p : zp);
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL single cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            else passed++;
            if (i == 1) begin
                checks++;
                if (!(bus.O_PrimValid === 1'b1 && bus.O_PrimVertexIdx === 2'd1 && bus.O_PrimVertex === 30'h1
                      && bus.O_PrimGSR === 8'h05 && bus.O_PrimLast === 1'b0))
                    $display("FAIL single_first_beat got valid=%b idx=%0d vtx=%h gsr=%h want 1/1/1/05",
                             bus.O_PrimValid, bus.O_PrimVertexIdx, bus.O_PrimVertex, bus.O_PrimGSR);
                else passed++;
            end
            if (i == 4) begin
                checks++;
                if (bus.O_PrimValid !== 1'b0 || bus.O_Count !== 3'd0)
                    $display("FAIL single_idle got valid=%b cnt=%0d want 0/0", bus.O_PrimValid, bus.O_Count);
                else passed++;
            end
        end
        checks++;
        if (got_beats != exp_beats)
            $display("FAIL single_beats got %0d beats want %0d in order", got_beats.size(), exp_beats.size());
        else passed++;
    endtask

    task automatic test_fill_overflow();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            cycle(1, 1, 0, rand_prim());
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL fill cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            else passed++;
            if (i == 2) begin
                checks++;
                if (bus.O_GPUStallSignal !== 1'b1 || bus.O_Count !== 3'd3)
                    $display("FAIL fill_stall got stall=%b cnt=%0d want 1/3", bus.O_GPUStallSignal, bus.O_Count);
                else passed++;
            end
        end
        checks++;
        if (bus.O_Overflow !== 1'b1 || bus.O_Count !== 3'd4)
            $display("FAIL fill_overflow got ovf=%b cnt=%0d want 1/4", bus.O_Overflow, bus.O_Count);
        else passed++;
    endtask

    task automatic test_full_pushpop();
        prim_t ps[4];
        bit done = 0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            ps[i] = rand_prim();
            cycle(1, 1, 0, ps[i]);
        end
        for (int i = 0; i < 6 && !done; i++) begin
            done = (m_beat == 3);
            cycle(done, 1, 1, rand_prim());
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL pushpop cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            else passed++;
        end
        checks++;
        if (!done || bus.O_Count !== 3'd4 || bus.O_Overflow !== 1'b0 || bus.O_PrimValid !== 1'b1
            || bus.O_PrimVertexIdx !== 2'd1 || bus.O_PrimVertex !== ps[1].a)
            $display("FAIL pushpop_full got cnt=%0d ovf=%b valid=%b idx=%0d vtx=%h want 4/0/1/1/%h",
                     bus.O_Count, bus.O_Overflow, bus.O_PrimValid, bus.O_PrimVertexIdx, bus.O_PrimVertex, ps[1].a);
        else passed++;
        for (int i = 0; i < 16; i++) cycle(0, 1, 1, zp);
        checks++;
        if (got_beats != exp_beats)
            $display("FAIL pushpop_beats got %0d beats want %0d in order", got_beats.size(), exp_beats.size());
        else passed++;
    endtask

    task automatic test_ready_toggle();
        bit pat [6] = '{0, 1, 0, 0, 1, 1};
        logic [46:0] prev;
        do_reset();
        cycle(1, 1, 0, rand_prim());
        prev = obs_vec();
        for (int i = 0; i < 6; i++) begin
            cycle(0, 1, pat[i], zp);
            checks++;
            if (obs_vec() !== exp_vec())
                $display("FAIL toggle cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            else passed++;
            if (i > 0 && !pat[i]) begin
                checks++;
                if (obs_vec() !== prev)
                    $display("FAIL toggle_hold cyc%0d got=%h want=%h", i, obs_vec(), prev);
                else passed++;
            end
            prev = obs_vec();
        end
        checks++;
        if (got_beats != exp_beats || got_beats.size() != 3)
            $display("FAIL toggle_beats got %0d beats want 3 in order", got_beats.size());
        else passed++;
    endtask

    task automatic test_lock();
        do_reset();
        for (int i = 0; i < 3; i++) cycle(1, 0, 1, rand_prim());
        checks++;
        if (bus.O_Count !== 3'd0 || bus.O_Overflow !== 1'b0 || bus.O_PrimValid !== 1'b0)
            $display("FAIL lock_ignored got cnt=%0d ovf=%b valid=%b want 0/0/0",
                     bus.O_Count, bus.O_Overflow, bus.O_PrimValid);
        else passed++;
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 1), $urandom_range(0, 4) != 0, $urandom_range(0, 4) < 3, rand_prim());
            checks++;
            if (obs_vec() !== exp_vec()) begin
                errs++;
                if (errs < 10) $display("FAIL random cyc%0d got=%h want=%h", i, obs_vec(), exp_vec());
            end else passed++;
        end
        for (int i = 0; i < 20; i++) cycle(0, 1, 1, zp);
        checks++;
        if (got_beats.size() != exp_beats.size())
            $display("FAIL random_beat_count got %0d want %0d", got_beats.size(), exp_beats.size());
        else passed++;
        for (int i = 0; i < got_beats.size() && i < exp_beats.size(); i++) begin
            checks++;
            if (got_beats[i] !== exp_beats[i]) begin
                if (errs < 10) $display("FAIL random_beat%0d got=%h want=%h", i, got_beats[i], exp_beats[i]);
                errs++;
            end else passed++;
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        cycle(1, 1, 0, rand_prim());
        cycle(1, 1, 0, rand_prim());
        cycle(0, 1, 1, zp);
        checks++;
        if (obs_vec() !== exp_vec() || bus.O_PrimVertexIdx !== 2'd2 || bus.O_Count !== 3'd2)
            $display("FAIL areset_setup got=%h want=%h (idx 2, cnt 2)", obs_vec(), exp_vec());
        else passed++;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.O_PrimValid, bus.O_PrimVertexIdx, bus.O_PrimLast, bus.O_PrimGSR, bus.O_PrimVertex,
             bus.O_Count, bus.O_GPUStallSignal, bus.O_Overflow} !== 47'h0)
            $display("FAIL areset_immediate got valid=%b idx=%0d vtx=%h cnt=%0d want all 0",
                     bus.O_PrimValid, bus.O_PrimVertexIdx, bus.O_PrimVertex, bus.O_Count);
        else passed++;
        do_reset();
        for (int i = 0; i < 3; i++) cycle(0, 1, 1, zp);
        checks++;
        if (bus.O_Count !== 3'd0 || bus.O_Overflow !== 1'b0 || bus.O_PrimValid !== 1'b0)
            $display("FAIL areset_after got cnt=%0d ovf=%b valid=%b want 0/0/0",
                     bus.O_Count, bus.O_Overflow, bus.O_PrimValid);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill_overflow();
        test_full_pushpop();
        test_ready_toggle();
        test_lock();
        test_random();
        test_async_reset();
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got no finish want finish before 200000");
        $fatal(1);
    end
endmodule
